sr_universal_nbit: RTL and testbench
====================================

Name: sr_universal_nbit

Overview:
- Parametrised universal shift register; the successor to the fixed 4-bit PIPO register.
- Width is configurable, and the block adds per-cycle operation modes: hold, logical and arithmetic shifts, rotates, parallel load and clear.
- Adds a multi-cycle burst mode: one command performs N single-bit steps, with busy/done handshake.
- Used as a datapath staging register and as a serialiser/deserialiser front end.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AMT_W, 4, width of the burst step-count input; must hold WIDTH (clog2(WIDTH)+1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  perform one `mode` operation this edge (IDLE only).
- mode  input  3  operation select (encoding below).
- din  input  WIDTH  parallel load data.
- sin_l  input  1  serial input entering the LSB on shift-left.
- sin_r  input  1  serial input entering the MSB on logical shift-right.
- start  input  1  burst request (IDLE only).
- amount  input  AMT_W  burst step count.
- dout  output  WIDTH  register contents (registered).
- sout_l  output  1  dout[WIDTH-1], combinational from register.
- sout_r  output  1  dout[0], combinational from register.
- busy  output  1  burst in progress (registered).
- done  output  1  one-cycle pulse after the final burst step (registered).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high and overrides everything. On a reset edge: dout=0, busy=0, done=0, step counter=0, FSM=IDLE. Reset mid-burst aborts the burst with no done pulse.
- Mode encoding (one step):
  - 000 hold.
  - 001 SL: {dout[WIDTH-2:0], sin_l}.
  - 010 SRL: {sin_r, dout[WIDTH-1:1]}.
  - 011 SRA: {dout[WIDTH-1], dout[WIDTH-1:1]}.
  - 100 ROL: {dout[WIDTH-2:0], dout[WIDTH-1]}.
  - 101 ROR: {dout[0], dout[WIDTH-1:1]}.
  - 110 LOAD: din.
  - 111 CLR: 0.
- FSM states: IDLE, RUN.
- IDLE, priority order:
  1. start=1 with amount!=0 and mode in 001..101: latch mode into burst_mode and amount into the counter; go to RUN; busy=1 from the next cycle. dout is unchanged on the accept edge; en is ignored.
  2. Otherwise, en=1: apply `mode` once on this edge.
  3. Otherwise: hold.
  - start with amount=0, or with mode 000/110/111, is ignored as a burst. en is still honoured the same cycle.
- RUN, each edge:
  - Apply burst_mode once and decrement the counter.
  - Serial inputs sin_l/sin_r are sampled at each step edge.
  - When the counter reaches 0 after the step: go to IDLE, busy=0, done=1 for exactly one cycle.
  - en, mode, start, din and amount are ignored throughout RUN.
- Timing: accept at edge E0, steps at E1..EN. busy is high from after E0 through EN. done is high during the cycle after EN, coincident with busy=0.
- A new start is accepted in the cycle done is high (FSM is already IDLE); back-to-back bursts are allowed.
- amount>WIDTH is legal: all N steps are performed (a rotate wraps repeatedly; a shift saturates to fill bits).
- done is 0 at all other times. busy and done are never simultaneously 1.

Test Plan:
- Reset: load 0xA5, then assert rst for 1 edge -> dout=0x00, busy=0, done=0 on the next cycle. rst during a RUN with 3 steps left -> dout=0, busy=0, no done pulse.
- Single-step modes: LOAD 0x96, then one edge each of SL(sin_l=1), SRL(sin_r=0), SRA, ROL, ROR -> 0x2D, 0x16, 0x0B, 0x16, 0x0B. Then CLR -> 0x00. en=0 -> holds.
- Arithmetic shift: LOAD 0x80, SRA x3 via en -> 0xC0, 0xE0, 0xF0. sout_l=1 and sout_r=0 throughout.
- Burst rotate: LOAD 0x81, start with mode=ROL, amount=3 -> busy high for exactly 3 cycles, dout 0x03, 0x06, 0x0C, done pulses once. en toggled with mode=CLR during RUN has no effect.
- Burst edge cases: amount=0 with start -> no busy. start with mode=LOAD and en=1 -> single load, no busy. amount=9 ROR on 0x01 -> final dout 0x80. New start in the done cycle -> accepted immediately.
- Serialiser: LOAD 0xC3, burst SL amount=8 with sin_l=0 -> sout_l sequence 1,1,0,0,0,0,1,1 over the burst, final dout=0x00.

Source files
------------

// File: rtl/sr_universal_nbit.sv
// Parametrised universal shift register with single-step modes and a counted
// multi-step burst mode (busy/done handshake).
module sr_universal_nbit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] dout,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SL   = 3'b001,
    M_SRL  = 3'b010,
    M_SRA  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_LOAD = 3'b110,
    M_CLR  = 3'b111
  } mode_e;

  // busy mirrors state_q == RUN and is the externally visible FSM state.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  mode_e            bmode_q, bmode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic [WIDTH-1:0] shift_op(
    input mode_e            m,
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] ld,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    r = v;
    case (m)
      M_HOLD: r = v;
      M_SL:   r = {v[WIDTH-2:0], sl};
      M_SRL:  r = {sr, v[WIDTH-1:1]};
      M_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      M_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      M_ROR:  r = {v[0], v[WIDTH-1:1]};
      M_LOAD: r = ld;
      M_CLR:  r = '0;
      default: r = v;
    endcase
    return r;
  endfunction

  // Only the shift/rotate modes make sense repeated; hold/load/clear are not bursts.
  logic burst_mode_ok;
  assign burst_mode_ok = (mode >= 3'd1) && (mode <= 3'd5);

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    bmode_d = bmode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (amount != '0) && burst_mode_ok) begin
          state_d = RUN;
          cnt_d   = amount;
          bmode_d = mode_e'(mode);
          busy_d  = 1'b1;
        end else if (en) begin
          dout_d = shift_op(mode_e'(mode), dout_q, din, sin_l, sin_r);
        end
      end
      RUN: begin
        dout_d = shift_op(bmode_q, dout_q, din, sin_l, sin_r);
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dout_q  <= '0;
      cnt_q   <= '0;
      bmode_q <= M_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      bmode_q <= bmode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dout   = dout_q;
  assign sout_l = dout_q[WIDTH-1];
  assign sout_r = dout_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_sr_universal_nbit.sv
// Scoreboard bench for sr_universal_nbit: directed scenarios then random traffic,
// expectations from an arithmetic reference model.
module tb_sr_universal_nbit;
  localparam int W  = 8;
  localparam int AW = 4;
  localparam int EW = W + 4;

  logic          clk = 1'b0;
  logic          rst, en, sin_l, sin_r, start;
  logic [2:0]    mode;
  logic [W-1:0]  din;
  logic [AW-1:0] amount;
  logic [W-1:0]  dout;
  logic          sout_l, sout_r, busy, done;

  sr_universal_nbit #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din),
    .sin_l(sin_l), .sin_r(sin_r), .start(start), .amount(amount),
    .dout(dout), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Expected vector: {dout, sout_l, sout_r, busy, done}
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  logic [W-1:0] m_dout = '0;
  int           m_left = 0;
  int           m_bmode = 0;
  logic         m_done = 1'b0;

  function automatic logic [W-1:0] ref_op(input int m, input logic [W-1:0] v,
                                          input logic [W-1:0] ld, input logic sl,
                                          input logic sr);
    logic [W-1:0] lsb_sl, msb_sr, msb_v, lsb_v;
    lsb_sl = {{(W-1){1'b0}}, sl};
    msb_sr = {sr, {(W-1){1'b0}}};
    msb_v  = {v[0], {(W-1){1'b0}}};
    lsb_v  = {{(W-1){1'b0}}, v[W-1]};
    case (m)
      1: return (v << 1) | lsb_sl;
      2: return (v >> 1) | msb_sr;
      3: return $signed(v) >>> 1;
      4: return (v << 1) | lsb_v;
      5: return (v >> 1) | msb_v;
      6: return ld;
      7: return '0;
      default: return v;
    endcase
  endfunction

  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [W-1:0] d, input logic sl, input logic sr,
                      input logic st, input logic [AW-1:0] amt);
    logic [EW-1:0] ev;
    rst = r; en = e; mode = m; din = d; sin_l = sl; sin_r = sr; start = st; amount = amt;
    if (r) begin
      m_dout = '0; m_left = 0; m_bmode = 0; m_done = 1'b0;
    end else if (m_left > 0) begin
      m_dout = ref_op(m_bmode, m_dout, d, sl, sr);
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end else begin
      m_done = 1'b0;
      if (st && amt != 0 && int'(m) >= 1 && int'(m) <= 5) begin
        m_left  = int'(amt);
        m_bmode = int'(m);
      end else if (e) begin
        m_dout = ref_op(int'(m), m_dout, d, sl, sr);
      end
    end
    ev = {m_dout, m_dout[W-1], m_dout[0], (m_left > 0), m_done};
    @(posedge clk);
    exp_q.push_back(ev);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, '0, 0, 0, 0, '0);
  endtask

  task automatic op(input logic [2:0] m, input logic [W-1:0] d, input logic sl, input logic sr);
    step(0, 1, m, d, sl, sr, 0, '0);
  endtask

  task automatic burst(input logic [2:0] m, input logic [AW-1:0] amt);
    step(0, 0, m, '0, 0, 0, 1, amt);
  endtask

  // Monitor: compares the DUT outputs against the oldest expectation each cycle.
  always @(negedge clk) begin
    logic [EW-1:0] ev, got;
    cyc++;
    if (exp_q.size() > 0) begin
      ev  = exp_q.pop_front();
      got = {dout, sout_l, sout_r, busy, done};
      checks++;
      if (got !== ev) begin
        errors++;
        $display("FAIL outputs cyc %0d: got dout=%h sout_l=%b sout_r=%b busy=%b done=%b, required dout=%h sout_l=%b sout_r=%b busy=%b done=%b",
                 cyc, got[EW-1:4], got[3], got[2], got[1], got[0],
                 ev[EW-1:4], ev[3], ev[2], ev[1], ev[0]);
      end
      if (busy === 1'b1 && done === 1'b1) begin
        errors++;
        $display("FAIL busy_done_overlap cyc %0d: got busy=1 done=1, required not both", cyc);
      end
    end
  end

  initial begin
    step(1, 0, 3'd0, '0, 0, 0, 0, '0);
    step(1, 0, 3'd0, '0, 0, 0, 0, '0);
    // Reset after a load
    op(3'd6, 8'hA5, 0, 0);
    step(1, 0, 3'd0, '0, 0, 0, 0, '0);
    idle(1);
    // Single-step modes
    op(3'd6, 8'h96, 0, 0);
    op(3'd1, '0, 1, 0);
    op(3'd2, '0, 0, 0);
    op(3'd3, '0, 0, 0);
    op(3'd4, '0, 0, 0);
    op(3'd5, '0, 0, 0);
    op(3'd7, '0, 0, 0);
    op(3'd6, 8'h5A, 0, 0);
    step(0, 0, 3'd7, '0, 0, 0, 0, '0);
    // Arithmetic shift
    op(3'd6, 8'h80, 0, 0);
    repeat (3) op(3'd3, '0, 0, 0);
    // Burst rotate with en/CLR noise during RUN
    op(3'd6, 8'h81, 0, 0);
    burst(3'd4, 4'd3);
    step(0, 1, 3'd7, 8'hFF, 1, 1, 1, 4'd5);
    step(0, 0, 3'd7, 8'hFF, 0, 1, 0, 4'd5);
    step(0, 1, 3'd7, 8'hFF, 1, 0, 1, 4'd2);
    idle(2);
    // Burst edge cases
    step(0, 0, 3'd4, '0, 0, 0, 1, 4'd0);
    step(0, 1, 3'd6, 8'h3C, 0, 0, 1, 4'd4);
    op(3'd6, 8'h01, 0, 0);
    burst(3'd5, 4'd9);
    idle(8);
    burst(3'd1, 4'd2);
    idle(1);
    // Reset mid-burst
    op(3'd6, 8'hF0, 0, 0);
    burst(3'd4, 4'd6);
    idle(3);
    step(1, 0, 3'd0, '0, 0, 0, 0, '0);
    idle(2);
    // Serialiser
    op(3'd6, 8'hC3, 0, 0);
    burst(3'd1, 4'd8);
    idle(9);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
           W'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 3) == 0), AW'($urandom_range(0, 12)));
    end
    idle(2);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
